selector_scan_reg: RTL and testbench



---
 rtl/selector_scan_reg.sv | 63 ++++++
 tb/tb_selector_scan_reg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/selector_scan_reg.sv
// Registered multi-channel 2^SEL_BITS:1 selector sharing one select register
// that is either loaded directly or auto-incremented in scan mode.
module selector_scan_reg #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned WIDTH    = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [CHANNELS*(2**SEL_BITS)*WIDTH-1:0]   i,
  input  logic [SEL_BITS-1:0]                       s_in,
  input  logic                                      load,
  input  logic                                      scan,
  input  logic [CHANNELS-1:0]                       e_n,
  output logic [CHANNELS*WIDTH-1:0]                 y,
  output logic [SEL_BITS-1:0]                       s_out,
  output logic                                      wrap
);

  localparam int unsigned NWORDS = 2**SEL_BITS;

  logic [SEL_BITS-1:0]       sel_q, sel_d;
  logic                      wrap_q, wrap_d;
  logic [CHANNELS*WIDTH-1:0] y_q, y_d;

  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (load) begin
      sel_d = s_in;
    end else if (scan) begin
      sel_d  = sel_q + SEL_BITS'(1);
      wrap_d = (sel_q == '1);
    end
  end

  // Outputs are built from the pre-edge select so a load/scan shows up on y one clock later.
  always_comb begin
    y_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (!e_n[c]) begin
        y_d[c*WIDTH +: WIDTH] = i[(c*NWORDS + 32'(sel_q))*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      wrap_q <= 1'b0;
      y_q    <= '0;
    end else begin
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign y     = y_q;
  assign s_out = sel_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_selector_scan_reg.sv
// Bench for selector_scan_reg: default (2x4:1x1) and wide (3x8:1x4) instances
// checked against a behavioural model and hand-derived tables.
module tb_selector_scan_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance A
  logic [7:0]  i_a = '0;
  logic [1:0]  s_in_a = '0;
  logic        load_a = 1'b0, scan_a = 1'b0;
  logic [1:0]  e_n_a = '0;
  logic [1:0]  y_a;
  logic [1:0]  s_out_a;
  logic        wrap_a;

  // Wide instance B
  logic [95:0] i_b = '0;
  logic [2:0]  s_in_b = '0;
  logic        load_b = 1'b0, scan_b = 1'b0;
  logic [2:0]  e_n_b = '0;
  logic [11:0] y_b;
  logic [2:0]  s_out_b;
  logic        wrap_b;

  selector_scan_reg dut_a (
    .clk(clk), .rst_n(rst_n), .i(i_a), .s_in(s_in_a), .load(load_a),
    .scan(scan_a), .e_n(e_n_a), .y(y_a), .s_out(s_out_a), .wrap(wrap_a)
  );

  selector_scan_reg #(.CHANNELS(3), .SEL_BITS(3), .WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i(i_b), .s_in(s_in_b), .load(load_b),
    .scan(scan_b), .e_n(e_n_b), .y(y_b), .s_out(s_out_b), .wrap(wrap_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          ma_sel = 0, mb_sel = 0;
  logic [1:0]  ma_y = '0;
  logic [11:0] mb_y = '0;
  logic        ma_wrap = 1'b0, mb_wrap = 1'b0;

  task automatic model_reset();
    ma_sel = 0; mb_sel = 0; ma_y = '0; mb_y = '0; ma_wrap = 1'b0; mb_wrap = 1'b0;
  endtask

  // Advance one clock (rst_n high), update the model, return at the falling edge.
  task automatic tick();
    int na, nb;
    logic [1:0]  ya;
    logic [11:0] yb;
    logic wa, wb;
    na = load_a ? int'(s_in_a) : (scan_a ? (ma_sel + 1) % 4 : ma_sel);
    wa = !load_a && scan_a && (ma_sel == 3);
    for (int c = 0; c < 2; c++) ya[c] = e_n_a[c] ? 1'b0 : i_a[c*4 + ma_sel];
    nb = load_b ? int'(s_in_b) : (scan_b ? (mb_sel + 1) % 8 : mb_sel);
    wb = !load_b && scan_b && (mb_sel == 7);
    for (int c = 0; c < 3; c++) yb[c*4 +: 4] = e_n_b[c] ? 4'h0 : i_b[(c*8 + mb_sel)*4 +: 4];
    @(posedge clk);
    ma_sel = na; ma_wrap = wa; ma_y = ya;
    mb_sel = nb; mb_wrap = wb; mb_y = yb;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_a = '1; i_b = '1; e_n_a = '0; e_n_b = '0;
    load_a = 1'b1; s_in_a = 2'd3; load_b = 1'b1; s_in_b = 3'd5; scan_a = 1'b1; scan_b = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (y_a !== 2'b00 || s_out_a !== 2'd0 || wrap_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_a: y=%b s_out=%0d wrap=%b, required y=00 s_out=0 wrap=0", y_a, s_out_a, wrap_a);
      end
      n_checks++;
      if (y_b !== 12'h000 || s_out_b !== 3'd0 || wrap_b !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_b: y=%h s_out=%0d wrap=%b, required 000/0/0", y_b, s_out_b, wrap_b);
      end
    end
    load_a = 1'b0; scan_a = 1'b0; load_b = 1'b0; scan_b = 1'b0;
    i_a = 8'b0001_0001;
    #2 rst_n = 1'b1;
    @(negedge clk);
    tick();
    n_checks++;
    if (y_a !== 2'b11 || s_out_a !== 2'd0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: y=%b s_out=%0d wrap=%b, required y=11 s_out=0 wrap=0", y_a, s_out_a, wrap_a);
    end
  endtask

  task automatic test_74153();
    logic [3:0] exp_y1, exp_y2;
    exp_y1 = 4'b1010; exp_y2 = 4'b0110;
    i_a = {4'b0110, 4'b1010};
    for (int pass = 0; pass < 2; pass++) begin
      e_n_a = (pass == 0) ? 2'b00 : 2'b01;
      for (int s = 0; s < 4; s++) begin
        s_in_a = 2'(s); load_a = 1'b1; tick();
        load_a = 1'b0; tick();
        n_checks++;
        if (y_a[0] !== (pass == 0 ? exp_y1[s] : 1'b0) || y_a[1] !== exp_y2[s]) begin
          n_fail++;
          $display("FAIL mux4_sel%0d_en%b: y=%b, required y2=%b y1=%b", s, e_n_a, y_a,
                   exp_y2[s], (pass == 0 ? exp_y1[s] : 1'b0));
        end
      end
    end
    e_n_a = 2'b00;
  endtask

  task automatic test_scan_wrap();
    int exp_s[4] = '{3, 0, 1, 2};
    bit exp_w[4] = '{0, 1, 0, 0};
    s_in_a = 2'd2; load_a = 1'b1; tick();
    load_a = 1'b0; scan_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (s_out_a !== 2'(exp_s[k]) || wrap_a !== exp_w[k] || y_a !== ma_y) begin
        n_fail++;
        $display("FAIL scan_step%0d: s_out=%0d wrap=%b y=%b, required s_out=%0d wrap=%b y=%b",
                 k, s_out_a, wrap_a, y_a, exp_s[k], exp_w[k], ma_y);
      end
    end
    scan_a = 1'b0;
  endtask

  task automatic test_load_priority();
    s_in_a = 2'd3; load_a = 1'b1; scan_a = 1'b0; tick();
    s_in_a = 2'd1; scan_a = 1'b1; tick();
    n_checks++;
    if (s_out_a !== 2'd1 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_scan: s_out=%0d wrap=%b, required s_out=1 wrap=0", s_out_a, wrap_a);
    end
    s_in_a = 2'd3; scan_a = 1'b0; tick();
    s_in_a = 2'd0; scan_a = 1'b1; tick();
    n_checks++;
    if (s_out_a !== 2'd0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load0_nowrap: s_out=%0d wrap=%b, required s_out=0 wrap=0", s_out_a, wrap_a);
    end
    load_a = 1'b0; scan_a = 1'b0;
  endtask

  task automatic test_wide();
    int prev_sel, wraps;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 8; k++) i_b[(c*8 + k)*4 +: 4] = 4'((c*8 + k) % 16);
    e_n_b = '0;
    s_in_b = 3'd0; load_b = 1'b1; tick();
    load_b = 1'b0; scan_b = 1'b1;
    wraps = 0;
    for (int step = 0; step < 16; step++) begin
      prev_sel = step % 8;
      if (step == 12) e_n_b = 3'b010;
      tick();
      if (wrap_b === 1'b1) wraps++;
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (y_b[c*4 +: 4] !== ((e_n_b[c] && step >= 12) ? 4'h0 : 4'((c*8 + prev_sel) % 16))) begin
          n_fail++;
          $display("FAIL wide_y_step%0d_ch%0d: y=%h, required %h", step, c, y_b[c*4 +: 4],
                   (e_n_b[c] && step >= 12) ? 4'h0 : 4'((c*8 + prev_sel) % 16));
        end
      end
      n_checks++;
      if (s_out_b !== 3'((step + 1) % 8)) begin
        n_fail++;
        $display("FAIL wide_sel_step%0d: s_out=%0d, required %0d", step, s_out_b, (step + 1) % 8);
      end
    end
    n_checks++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL wide_wrap_count: got %0d pulses, required 2", wraps);
    end
    scan_b = 1'b0; e_n_b = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      i_a = 8'($urandom); s_in_a = 2'($urandom); e_n_a = 2'($urandom);
      load_a = ($urandom_range(0, 3) == 0); scan_a = $urandom_range(0, 1) == 1;
      i_b = {$urandom, $urandom, $urandom}; s_in_b = 3'($urandom); e_n_b = 3'($urandom);
      load_b = ($urandom_range(0, 5) == 0); scan_b = $urandom_range(0, 3) != 0;
      tick();
      n_checks++;
      if (y_a !== ma_y || s_out_a !== 2'(ma_sel) || wrap_a !== ma_wrap) begin
        n_fail++;
        $display("FAIL rand_a_%0d: y=%b s=%0d w=%b, required y=%b s=%0d w=%b",
                 k, y_a, s_out_a, wrap_a, ma_y, ma_sel, ma_wrap);
      end
      n_checks++;
      if (y_b !== mb_y || s_out_b !== 3'(mb_sel) || wrap_b !== mb_wrap) begin
        n_fail++;
        $display("FAIL rand_b_%0d: y=%h s=%0d w=%b, required y=%h s=%0d w=%b",
                 k, y_b, s_out_b, wrap_b, mb_y, mb_sel, mb_wrap);
      end
    end
    load_a = 1'b0; scan_a = 1'b0; load_b = 1'b0; scan_b = 1'b0; e_n_a = '0; e_n_b = '0;
  endtask

  task automatic test_async_reset();
    i_a = '1; e_n_a = '0;
    s_in_a = 2'd1; load_a = 1'b1; tick();
    load_a = 1'b0; scan_a = 1'b1; tick();
    n_checks++;
    if (s_out_a !== 2'd2 || y_a !== 2'b11) begin
      n_fail++;
      $display("FAIL async_pre: s_out=%0d y=%b, required s_out=2 y=11", s_out_a, y_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (y_a !== 2'b00 || s_out_a !== 2'd0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: y=%b s_out=%0d wrap=%b, required 00/0/0", y_a, s_out_a, wrap_a);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (s_out_a !== 2'd1 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_resume: s_out=%0d wrap=%b, required s_out=1 wrap=0", s_out_a, wrap_a);
    end
    scan_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_74153();
    test_scan_wrap();
    test_load_priority();
    test_wide();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

endmodule
